button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Input stage ahead of the snake game core. Synchronises six raw push-button pins,
//   debounces them on a shared sample tick and produces clean levels plus one-cycle
//   press pulses. Also owns the latched pause state and the restart pulse.
//   Outputs feed the core's i_up/i_down/i_left/i_right/i_pause/i_restart directly.
// PARAMETERS
//   PRESCALE        25000  clk cycles per debounce sample tick (~1 ms at 25.175 MHz)
//   STABLE_SAMPLES  8      consecutive differing samples needed to flip a debounced level
//   REPEAT_DELAY    300    sample ticks held before the first auto-repeat (macro only)
//   REPEAT_RATE     100    sample ticks between auto-repeats (macro only)
// PORTS
//   clk        in   1  system clock (VGA pixel clock)
//   rst        in   1  asynchronous active-high reset
//   i_btn      in   6  raw pins, bit 0..5 = up, down, left, right, pause, restart
//   o_level    out  6  debounced level per button
//   o_press    out  6  one-cycle pulse on each debounced 0->1 edge (and repeats)
//   o_pause    out  1  latched pause state, toggled by pause presses
//   o_restart  out  1  one-cycle pulse, equals o_press[5]
// BEHAVIOUR
//   - Reset (async assert, sync release): sync flops, prescaler, stable counters,
//     o_level, o_press, o_pause, o_restart and repeat state all 0.
//   - Synchroniser: 2 flops per bit; sync[i] lags i_btn[i] by 2 clk.
//   - Prescaler: counts 0..PRESCALE-1; sample_tick is high for the one cycle at
//     PRESCALE-1, then wraps to 0. Free-running, shared by all bits.
//   - Per bit, stable counter of width $clog2(STABLE_SAMPLES+1):
//       sync==o_level on any cycle -> counter cleared (glitches restart the count).
//       sync!=o_level on sample_tick -> counter+1.
//       Increment that reaches STABLE_SAMPLES -> o_level flips, counter cleared.
//   - o_press[i] is registered: high exactly in the cycle o_level[i] first reads 1.
//     Release produces no pulse.
//   - Latency: a clean edge reaches o_level after 2 clk + STABLE_SAMPLES sample
//     ticks, i.e. between 2+(STABLE_SAMPLES-1)*PRESCALE+1 and
//     2+STABLE_SAMPLES*PRESCALE clk.
//   - Pause/restart (registered, updated on o_press):
//       press[5]                      -> o_pause<=0, o_restart=1
//       press[4] and not press[5]     -> o_pause<=~o_pause
//       Both in one cycle             -> restart wins, o_pause=0.
//   - Several buttons may pulse in the same cycle; no priority among bits 0..3.
//   - Reset mid-debounce discards partial counts; outputs go to 0 immediately.
// CONFIGURATION
//   BUTTON_AUTOREPEAT_EN defined: applies to direction bits 0..3.
//     - One shared repeat counter, in sample ticks, cleared on any change of
//       o_level[3:0].
//     - While o_level[3:0]!=0, a pulse fires when the count reaches REPEAT_DELAY,
//       then every REPEAT_RATE ticks.
//     - Each pulse is one cycle on o_press[i] for every held bit i.
//     - Bits 4 and 5 never repeat.
//   Not defined: no repeat logic is synthesised; o_press fires only on
//     debounced rising edges.
// TESTING  (PRESCALE=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2)
//   1. Hold i_btn[0]=1 from cycle 10 -> o_level[0] rises within cycles 21..24;
//      o_press[0] is high for exactly 1 cycle, in that same cycle.
//   2. Toggle i_btn[2] every 6 cycles for 100 cycles -> o_level[2] stays 0 and
//      o_press stays 0.
//   3. Press/release pause twice, each held 40 cycles -> o_pause goes 0->1->0
//      and o_restart stays 0.
//   4. o_pause=1, then raise pause and restart in the same cycle -> o_pause=0,
//      one o_restart pulse, no toggle.
//   5. Assert rst mid-debounce, async and not clock-aligned -> all outputs 0
//      before the next edge; counting restarts from 0 after release.
//   6. BUTTON_AUTOREPEAT_EN, hold i_btn[3] for 200 cycles -> pulse at level rise,
//      then at +5 ticks (+20 cycles), then every 8 cycles.
//      Without the macro: a single pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects six push buttons; owns the pause latch and restart pulse.
// Optional direction auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int PRESCALE       = 25000,
  parameter int STABLE_SAMPLES = 8,
  parameter int REPEAT_DELAY   = 300,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_btn,
  output logic [5:0] o_level,
  output logic [5:0] o_press,
  output logic       o_pause,
  output logic       o_restart
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STABLE_SAMPLES - 1);

  logic [5:0]         sync_a;
  logic [5:0]         sync_b;
  logic [PW-1:0]      ps_cnt;
  logic               sample_tick;
  logic [5:0][SW-1:0] st_cnt;
  logic [5:0][SW-1:0] st_cnt_next;
  logic [5:0]         level_next;
  logic [5:0]         rise;
  logic [5:0]         edge_press;

  assign sample_tick = (ps_cnt == PS_LAST);

  // Any cycle where the synced pin agrees with the level restarts the count.
  always_comb begin
    st_cnt_next = st_cnt;
    level_next  = o_level;
    for (int i = 0; i < 6; i++) begin
      if (sync_b[i] == o_level[i]) begin
        st_cnt_next[i] = '0;
      end else if (sample_tick) begin
        if (st_cnt[i] == ST_LAST) begin
          level_next[i]  = ~o_level[i];
          st_cnt_next[i] = '0;
        end else begin
          st_cnt_next[i] = st_cnt[i] + 1'b1;
        end
      end
    end
    rise = level_next & ~o_level;
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_inc;
  logic          rep_armed;
  logic          rep_fire;
  logic          dir_change;

  // rep_armed selects the initial delay versus the steady repeat period.
  always_comb begin
    rep_inc    = rep_cnt + 1'b1;
    dir_change = (level_next[3:0] != o_level[3:0]);
    rep_fire   = sample_tick && (o_level[3:0] != 4'b0000) && !dir_change &&
                 (rep_armed ? (rep_inc == RW'(REPEAT_RATE)) : (rep_inc == RW'(REPEAT_DELAY)));
    edge_press = rise | {2'b00, (rep_fire ? o_level[3:0] : 4'b0000)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (dir_change) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (sample_tick && (o_level[3:0] != 4'b0000)) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_inc;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign edge_press = rise;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      ps_cnt    <= '0;
      st_cnt    <= '0;
      o_level   <= '0;
      o_press   <= '0;
      o_pause   <= 1'b0;
      o_restart <= 1'b0;
    end else begin
      sync_a    <= i_btn;
      sync_b    <= sync_a;
      ps_cnt    <= sample_tick ? '0 : ps_cnt + 1'b1;
      st_cnt    <= st_cnt_next;
      o_level   <= level_next;
      o_press   <= edge_press;
      o_restart <= edge_press[5];
      // Restart clears pause even when a pause press lands in the same cycle.
      if (o_press[5]) begin
        o_pause <= 1'b0;
      end else if (o_press[4]) begin
        o_pause <= ~o_pause;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner at PRESCALE=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.
// Expected press vectors are queued with the stimulus and popped whenever o_press pulses.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [5:0] i_btn;
  logic [5:0] o_level;
  logic [5:0] o_press;
  logic       o_pause;
  logic       o_restart;

  logic [5:0] exp_q[$];
  int pass_cnt;
  int total_cnt;
  int restart_cnt;

  button_conditioner #(
    .PRESCALE(4),
    .STABLE_SAMPLES(3),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_btn(i_btn),
    .o_level(o_level),
    .o_press(o_press),
    .o_pause(o_pause),
    .o_restart(o_restart)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int b, input logic val, input int limit, output int n);
    n = 0;
    while (o_level[b] !== val && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Pops one expected press vector per observed pulse cycle.
  task automatic monitor();
    logic [5:0] prev;
    logic [5:0] exp;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (o_restart || o_press[5]) begin
          total_cnt++;
          if (o_restart !== o_press[5])
            $display("FAIL restart_eq_press5: got o_restart=%b o_press[5]=%b", o_restart, o_press[5]);
          else pass_cnt++;
        end
        if (o_press !== 6'b0) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_press: got %b required no pulse at %0t", o_press, $time);
          end else begin
            exp = exp_q.pop_front();
            if (o_press !== exp)
              $display("FAIL press_value: got %b required %b at %0t", o_press, exp, $time);
            else pass_cnt++;
          end
        end
        if ((o_level & ~prev) != 6'b0) begin
          total_cnt++;
          if (((o_level & ~prev) & ~o_press) != 6'b0)
            $display("FAIL press_on_rise: level rose %b but o_press=%b", o_level & ~prev, o_press);
          else pass_cnt++;
        end
        restart_cnt += int'(o_restart);
      end
      prev = o_level;
    end
  endtask

  task automatic check_queue(input string name);
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_pending: got %0d outstanding presses required 0", name, exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_btn = '0;
    #2 rst = 1'b1;
    #20;
    total_cnt++;
    if ({o_level, o_press, o_pause, o_restart} !== 14'b0)
      $display("FAIL reset_outputs: got %b required 0", {o_level, o_press, o_pause, o_restart});
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
  endtask

  task automatic test_press_latency();
    int n;
    i_btn[0] = 1'b1;
    exp_q.push_back(6'b000001);
    wait_level(0, 1'b1, 30, n);
    total_cnt++;
    if (n < 11 || n > 14) $display("FAIL rise_latency: got %0d cycles required 11..14", n);
    else pass_cnt++;
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 30, n);
    total_cnt++;
    if (n < 11 || n > 14) $display("FAIL fall_latency: got %0d cycles required 11..14", n);
    else pass_cnt++;
    tick(4);
    check_queue("press_latency");
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k % 6 == 0) i_btn[2] = ~i_btn[2];
      tick(1);
      seen |= o_level[2];
    end
    i_btn[2] = 1'b0;
    tick(20);
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL glitch_level: got level high required 0");
    else pass_cnt++;
    check_queue("glitch");
  endtask

  task automatic test_pause();
    int r0;
    r0 = restart_cnt;
    for (int k = 0; k < 2; k++) begin
      i_btn[4] = 1'b1;
      exp_q.push_back(6'b010000);
      tick(40);
      i_btn[4] = 1'b0;
      tick(40);
      total_cnt++;
      if (o_pause !== ((k == 0) ? 1'b1 : 1'b0))
        $display("FAIL pause_toggle_%0d: got %b required %b", k, o_pause, (k == 0));
      else pass_cnt++;
    end
    total_cnt++;
    if (restart_cnt != r0) $display("FAIL pause_no_restart: got %0d pulses required 0", restart_cnt - r0);
    else pass_cnt++;
    check_queue("pause");
  endtask

  task automatic test_pause_restart();
    int r0;
    i_btn[4] = 1'b1;
    exp_q.push_back(6'b010000);
    tick(40);
    i_btn[4] = 1'b0;
    tick(40);
    total_cnt++;
    if (o_pause !== 1'b1) $display("FAIL pr_pause_set: got %b required 1", o_pause);
    else pass_cnt++;
    r0 = restart_cnt;
    i_btn[5:4] = 2'b11;
    exp_q.push_back(6'b110000);
    tick(40);
    total_cnt++;
    if (o_pause !== 1'b0) $display("FAIL pr_restart_wins: got %b required 0", o_pause);
    else pass_cnt++;
    total_cnt++;
    if (restart_cnt != r0 + 1) $display("FAIL pr_restart_count: got %0d required 1", restart_cnt - r0);
    else pass_cnt++;
    i_btn[5:4] = 2'b00;
    tick(40);
    total_cnt++;
    if (o_pause !== 1'b0) $display("FAIL pr_after_release: got %b required 0", o_pause);
    else pass_cnt++;
    check_queue("pause_restart");
  endtask

  task automatic test_back_to_back();
    i_btn[0] = 1'b1;
    i_btn[2] = 1'b1;
    exp_q.push_back(6'b000101);
    tick(16);
    total_cnt++;
    if (o_level !== 6'b000101) $display("FAIL multi_level: got %b required 000101", o_level);
    else pass_cnt++;
    i_btn[0] = 1'b0;
    i_btn[2] = 1'b0;
    tick(20);
    total_cnt++;
    if (o_level !== 6'b0) $display("FAIL multi_release: got %b required 0", o_level);
    else pass_cnt++;
    check_queue("back_to_back");
  endtask

  task automatic test_reset_mid();
    int n;
    i_btn[4] = 1'b1;
    exp_q.push_back(6'b010000);
    tick(40);
    i_btn[4] = 1'b0;
    tick(40);
    i_btn[1] = 1'b1;
    exp_q.push_back(6'b000010);
    wait_level(1, 1'b1, 30, n);
    i_btn[3] = 1'b1;
    tick(6);
    total_cnt++;
    if ({o_pause, o_level[1]} !== 2'b11) $display("FAIL rm_before: got %b required 11", {o_pause, o_level[1]});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({o_level, o_press, o_pause, o_restart} !== 14'b0)
      $display("FAIL rm_async_clear: got %b required 0", {o_level, o_press, o_pause, o_restart});
    else pass_cnt++;
    check_queue("reset_mid_pre");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(6'b001010);
    wait_level(1, 1'b1, 30, n);
    total_cnt++;
    if (n != 12 || o_level[3] !== 1'b1)
      $display("FAIL rm_restart_count: got %0d cycles level3=%b required 12 and 1", n, o_level[3]);
    else pass_cnt++;
    i_btn[1] = 1'b0;
    i_btn[3] = 1'b0;
    tick(20);
    check_queue("reset_mid");
  endtask

  task automatic test_autorepeat();
    int n;
    int pulses;
    int exp_pulses;
    logic exp_p;
    i_btn[3] = 1'b1;
    exp_q.push_back(6'b001000);
    wait_level(3, 1'b1, 30, n);
`ifdef BUTTON_AUTOREPEAT_EN
    for (int k = 0; k < 22; k++) exp_q.push_back(6'b001000);
    exp_pulses = 23;
`else
    exp_pulses = 1;
`endif
    pulses = 1;
    for (int c = 1; c <= 200; c++) begin
      tick(1);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_p = (c >= 20) && ((c - 20) % 8 == 0) && (c < 192);
`else
      exp_p = 1'b0;
`endif
      if (exp_p || o_press[3]) begin
        total_cnt++;
        if (o_press[3] !== exp_p)
          $display("FAIL repeat_timing: got %b required %b at +%0d cycles", o_press[3], exp_p, c);
        else pass_cnt++;
      end
      pulses += int'(o_press[3]);
      if (c == 180) i_btn[3] = 1'b0;
    end
    total_cnt++;
    if (pulses != exp_pulses) $display("FAIL repeat_count: got %0d required %0d", pulses, exp_pulses);
    else pass_cnt++;
    total_cnt++;
    if (o_level !== 6'b0) $display("FAIL repeat_release: got %b required 0", o_level);
    else pass_cnt++;
    check_queue("autorepeat");
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    restart_cnt = 0;
    test_reset();
    fork
      monitor();
    join_none
    test_press_latency();
    test_glitch();
    test_pause();
    test_pause_restart();
    test_back_to_back();
    test_reset_mid();
    test_autorepeat();
    tick(5);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
